led_matrix_bcm_scan: RTL and testbench

// - Parametrised HUB75 row-scan controller; successor to the fixed 1-plane row scanner.
// - Sequences rows x bit-planes (binary code modulation) and drives row_addr/blank/latch.
// - Requests the line shifter for the next (row, plane) while the current one is displayed.
// - Applies 8-bit global brightness. Sits between the frame-buffer line shifter and the panel pins.

---
 rtl/led_matrix_pkg.sv | 29 ++
 rtl/bcm_display_timer.sv | 39 +++
 rtl/led_matrix_bcm_scan.sv | 133 +++++++++++++
 tb/tb_led_matrix_bcm_scan.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
// rtl/led_matrix_pkg.sv - shared scan-controller types, default geometry and width helpers
package led_matrix_pkg;

    localparam int DEF_NUM_ROWS    = 32;
    localparam int DEF_PWM_BITS    = 7;
    localparam int DEF_BASE_TICKS  = 8;
    localparam int DEF_DEAD_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_PRIME,
        ST_WAIT,
        ST_BLANK,
        ST_LATCH,
        ST_ADDR,
        ST_BEGIN,
        ST_DEAD,
        ST_UNBLANK
    } scan_state_t;

    // Index width that stays at least one bit for degenerate sizes.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int period_w(input int base_ticks, input int pwm_bits);
        return $clog2(base_ticks) + pwm_bits;
    endfunction

endpackage

// File: rtl/bcm_display_timer.sv
// rtl/bcm_display_timer.sv - per-plane display period countdown with brightness-limited on window
module bcm_display_timer #(
    parameter int PER_W = 10
) (
    input  logic             clk_25MHz,
    input  logic             rst_n,
    input  logic             load,
    input  logic [PER_W-1:0] period,
    input  logic [PER_W-1:0] on_ticks,
    output logic             blank_req,
    output logic             disp_done
);

    logic [PER_W-1:0] cnt;
    logic [PER_W-1:0] period_q;
    logic [PER_W-1:0] on_q;
    logic [PER_W:0]   elapsed_next;

    always_ff @(posedge clk_25MHz) begin
        if (!rst_n) begin
            cnt      <= '0;
            period_q <= '0;
            on_q     <= '0;
        end else if (load) begin
            cnt      <= period;
            period_q <= period;
            on_q     <= on_ticks;
        end else if (cnt != '0) begin
            cnt <= cnt - PER_W'(1);
        end
    end

    // blank_req tells the scanner what blank must be after this edge, so the
    // LEDs stay lit for exactly on_ticks cycles after the unblank edge.
    assign elapsed_next = {1'b0, period_q} - {1'b0, cnt} + (PER_W + 1)'(1);
    assign blank_req    = elapsed_next >= {1'b0, on_q};
    assign disp_done    = (cnt == '0);

endmodule

// File: rtl/led_matrix_bcm_scan.sv
// rtl/led_matrix_bcm_scan.sv - HUB75 row x bit-plane BCM scan controller (LED_DEAD_TIME_EN adds post-row blanking)
module led_matrix_bcm_scan
    import led_matrix_pkg::*;
#(
    parameter  int NUM_ROWS    = DEF_NUM_ROWS,
    parameter  int PWM_BITS    = DEF_PWM_BITS,
    parameter  int BASE_TICKS  = DEF_BASE_TICKS,
    parameter  int DEAD_CYCLES = DEF_DEAD_CYCLES,
    localparam int ROW_W       = idx_w(NUM_ROWS),
    localparam int PL_W        = idx_w(PWM_BITS),
    localparam int PER_W       = period_w(BASE_TICKS, PWM_BITS),
    localparam int DEAD_W      = idx_w(DEAD_CYCLES)
) (
    input  logic             clk_25MHz,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [7:0]       brightness,
    output logic [ROW_W-1:0] row_addr,
    output logic             blank,
    output logic             latch,
    output logic             next_line_begin,
    input  logic             next_line_done,
    output logic [ROW_W-1:0] next_line_addr,
    output logic [PL_W-1:0]  next_line_plane,
    output logic             frame_start
);

    scan_state_t       state;
    logic [PL_W-1:0]   cur_plane;
    logic              shift_ready;
    logic [DEAD_W-1:0] dead_cnt;
    logic [PER_W-1:0]  period_calc;
    logic [PER_W-1:0]  on_calc;
    logic [PER_W+7:0]  product;
    logic              blank_req;
    logic              disp_done;

    always_comb begin
        period_calc = PER_W'(BASE_TICKS) << cur_plane;
        product     = {8'd0, period_calc} * {{PER_W{1'b0}}, brightness};
        on_calc     = PER_W'(product >> 8);
    end

    bcm_display_timer #(.PER_W(PER_W)) u_timer (
        .clk_25MHz (clk_25MHz),
        .rst_n     (rst_n),
        .load      (state == ST_UNBLANK),
        .period    (period_calc),
        .on_ticks  (on_calc),
        .blank_req (blank_req),
        .disp_done (disp_done)
    );

    always_ff @(posedge clk_25MHz) begin
        if (!rst_n) begin
            state           <= ST_PRIME;
            blank           <= 1'b1;
            latch           <= 1'b0;
            row_addr        <= '0;
            next_line_begin <= 1'b0;
            next_line_addr  <= '0;
            next_line_plane <= '0;
            cur_plane       <= '0;
            frame_start     <= 1'b0;
            shift_ready     <= 1'b0;
            dead_cnt        <= '0;
        end else begin
            next_line_begin <= 1'b0;
            frame_start     <= 1'b0;
            // A done arriving alongside begin belongs to the abandoned request.
            if (next_line_begin)
                shift_ready <= 1'b0;
            else if (next_line_done)
                shift_ready <= 1'b1;

            case (state)
                ST_PRIME: begin
                    next_line_begin <= 1'b1;
                    state           <= ST_WAIT;
                end
                ST_WAIT: begin
                    blank <= blank_req;
                    if (shift_ready && disp_done && enable)
                        state <= ST_BLANK;
                end
                ST_BLANK: begin
                    blank <= 1'b1;
                    state <= ST_LATCH;
                end
                ST_LATCH: begin
                    latch <= 1'b1;
                    state <= ST_ADDR;
                end
                ST_ADDR: begin
                    latch     <= 1'b0;
                    row_addr  <= next_line_addr;
                    cur_plane <= next_line_plane;
                    if (next_line_addr == '0 && next_line_plane == '0)
                        frame_start <= 1'b1;
                    if (next_line_plane == PL_W'(PWM_BITS - 1)) begin
                        next_line_plane <= '0;
                        next_line_addr  <= (next_line_addr == ROW_W'(NUM_ROWS - 1)) ?
                                           '0 : next_line_addr + ROW_W'(1);
                    end else begin
                        next_line_plane <= next_line_plane + PL_W'(1);
                    end
                    state <= ST_BEGIN;
                end
                ST_BEGIN: begin
                    next_line_begin <= 1'b1;
                    dead_cnt        <= DEAD_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
`ifdef LED_DEAD_TIME_EN
                    state           <= ST_DEAD;
`else
                    state           <= ST_UNBLANK;
`endif
                end
                ST_DEAD: begin
                    if (dead_cnt == '0)
                        state <= ST_UNBLANK;
                    else
                        dead_cnt <= dead_cnt - DEAD_W'(1);
                end
                ST_UNBLANK: begin
                    blank <= (on_calc == '0);
                    state <= ST_WAIT;
                end
                default: state <= ST_PRIME;
            endcase
        end
    end

endmodule

// File: tb/tb_led_matrix_bcm_scan.sv
// tb/tb_led_matrix_bcm_scan.sv - randomized scan bench against an event-timing reference model
module tb_led_matrix_bcm_scan;

    localparam int NR = 4;
    localparam int PB = 2;
    localparam int BT = 4;

    logic       clk_25MHz = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] brightness = 8'd255;
    logic       next_line_done = 1'b0;
    logic [1:0] row_addr;
    logic       blank;
    logic       latch;
    logic       next_line_begin;
    logic [1:0] next_line_addr;
    logic [0:0] next_line_plane;
    logic       frame_start;

    led_matrix_bcm_scan #(
        .NUM_ROWS(NR), .PWM_BITS(PB), .BASE_TICKS(BT), .DEAD_CYCLES(2)
    ) dut (
        .clk_25MHz       (clk_25MHz),
        .rst_n           (rst_n),
        .enable          (enable),
        .brightness      (brightness),
        .row_addr        (row_addr),
        .blank           (blank),
        .latch           (latch),
        .next_line_begin (next_line_begin),
        .next_line_done  (next_line_done),
        .next_line_addr  (next_line_addr),
        .next_line_plane (next_line_plane),
        .frame_start     (frame_start)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    int cyc = 0;
    always @(posedge clk_25MHz) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: event times derived from shifter delay, plane period and enable.
    int beg_exp = -1, latch_exp = -1, ready_cyc = -1, done_cyc = -1, frame_exp = -1;
    int lo = -1, hi = -2, disp_per = 0;
    int nrow = 0, npl = 0, crow = 0, cpl = 0;
    bit outstanding = 0, rst_prev = 0;
    int dlo = 10, dhi = 10;
    int n_latch = 0, obs_latch = 0, obs_begin = 0;
    int low_cnt = 0, last_low = 0, last_pl = 0;
    int first_beg = -1, first_latch = -1, latch_prev = -1, latch_last = -1;
    int frame_prev = -1, frame_last = -1, n_frame = 0;

    initial forever begin
        int d, on;
        @(negedge clk_25MHz);
        if (!rst_n) begin
            beg_exp = -1; latch_exp = -1; ready_cyc = -1; done_cyc = -1; frame_exp = -1;
            lo = -1; hi = -2; disp_per = 0;
            nrow = 0; npl = 0; crow = 0; cpl = 0;
            outstanding = 0; low_cnt = 0; rst_prev = 0;
            next_line_done = 1'b0;
        end else if (!rst_prev) begin
            chk("reset_blank", int'(blank), 1);
            chk("reset_latch", int'(latch), 0);
            chk("reset_row_addr", int'(row_addr), 0);
            chk("reset_begin", int'(next_line_begin), 0);
            chk("reset_frame_start", int'(frame_start), 0);
            chk("reset_next_addr", int'(next_line_addr), 0);
            chk("reset_next_plane", int'(next_line_plane), 0);
            beg_exp  = cyc + 1;
            rst_prev = 1;
            next_line_done = 1'b0;
        end else begin
            if (ready_cyc >= 0 && cyc >= ready_cyc && enable) begin
                latch_exp = cyc + 3;
                ready_cyc = -1;
            end
            chk("begin", int'(next_line_begin), int'(cyc == beg_exp));
            chk("latch", int'(latch), int'(cyc == latch_exp));
            chk("blank", int'(blank), int'(!(cyc >= lo && cyc <= hi)));
            chk("row_addr", int'(row_addr), crow);
            chk("frame_start", int'(frame_start), int'(cyc == frame_exp));
            chk("next_addr", int'(next_line_addr), nrow);
            chk("next_plane", int'(next_line_plane), npl);
            if (next_line_begin) begin
                chk("begin_while_busy", int'(outstanding), 0);
                obs_begin++;
            end
            if (latch) obs_latch++;
            if (frame_start) begin
                frame_prev = frame_last;
                frame_last = cyc;
                n_frame++;
            end
            if (!blank) low_cnt++;
            if (cyc == beg_exp) begin
                d = $urandom_range(dhi, dlo);
                done_cyc = cyc + d;
                outstanding = 1;
                ready_cyc = cyc + ((d > disp_per) ? d : disp_per) + 1;
                on = (disp_per * int'(brightness)) >> 8;
                lo = cyc + 1;
                hi = cyc + on;
                if (first_beg < 0) first_beg = cyc;
            end
            if (cyc == latch_exp) begin
                last_low = low_cnt;
                last_pl  = cpl;
                low_cnt  = 0;
                crow     = nrow;
                cpl      = npl;
                disp_per = BT << npl;
                if (nrow == 0 && npl == 0) frame_exp = cyc + 1;
                if (npl == PB - 1) begin
                    npl  = 0;
                    nrow = (nrow + 1) % NR;
                end else begin
                    npl = npl + 1;
                end
                beg_exp = cyc + 2;
                n_latch++;
                latch_prev = latch_last;
                latch_last = cyc;
                if (first_latch < 0) first_latch = cyc;
            end
            next_line_done = (cyc == done_cyc);
            if (cyc == done_cyc) outstanding = 0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_25MHz);
        #2;
    endtask

    task automatic wait_latch(input int target);
        int budget;
        budget = 3000;
        while (n_latch < target && budget > 0) begin
            @(negedge clk_25MHz);
            #1;
            budget--;
        end
        if (n_latch < target) chk("latch_timeout", n_latch, target);
    endtask

    initial begin
        int o_latch, o_begin, budget, f0;
        rst_n = 1'b0;
        enable = 1'b1;
        brightness = 8'd255;
        dlo = 10; dhi = 10;
        step(3);
        rst_n = 1'b1;

        wait_latch(1);
        chk("first_latch_delay", first_latch - first_beg, 14);
        dlo = 3; dhi = 3;
        step(2);
        chk("first_frame_after_latch", frame_last - first_latch, 1);

        f0 = n_frame;
        budget = 1000;
        while (n_frame < f0 + 3 && budget > 0) begin
            step(1);
            budget--;
        end
        chk("frame_period", frame_last - frame_prev, 96);
        for (int i = 0; i < 2; i++) begin
            wait_latch(n_latch + 1);
            chk("low_cycles_255", last_low, (last_pl != 0) ? 7 : 3);
        end

        step(1);
        brightness = 8'd128;
        wait_latch(n_latch + 1);
        for (int i = 0; i < 2; i++) begin
            wait_latch(n_latch + 1);
            chk("low_cycles_128", last_low, (last_pl != 0) ? 4 : 2);
        end
        step(1);
        brightness = 8'd0;
        wait_latch(n_latch + 1);
        for (int i = 0; i < 2; i++) begin
            wait_latch(n_latch + 1);
            chk("low_cycles_0", last_low, 0);
        end

        dlo = 1;
        for (int i = 0; i < 40; i++) begin
            brightness = 8'($urandom);
            dhi = $urandom_range(12, 1);
            wait_latch(n_latch + 1);
        end

        dlo = 24; dhi = 24;
        wait_latch(n_latch + 3);
        chk("slow_shifter_step", latch_last - latch_prev, 30);

        dlo = 1; dhi = 6;
        brightness = 8'd200;
        wait_latch(n_latch + 2);
        step(5);
        enable = 1'b0;
        step(20);
        o_latch = obs_latch;
        o_begin = obs_begin;
        step(40);
        chk("parked_no_latch", obs_latch, o_latch);
        chk("parked_no_begin", obs_begin, o_begin);
        chk("parked_blank", int'(blank), 1);
        enable = 1'b1;
        wait_latch(n_latch + 4);

        budget = 200;
        do begin
            @(negedge clk_25MHz);
            #1;
            budget--;
        end while (beg_exp != cyc + 1 && budget > 0);
        if (budget == 0) chk("unblank_wait_timeout", 0, 1);
        step(1);
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        dlo = 1; dhi = 15;
        for (int i = 0; i < 12; i++) begin
            brightness = 8'($urandom);
            wait_latch(n_latch + 1);
        end
        step(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
